display_ctrl: RTL

DISPLAY_CTRL -- requirements
Module: display_ctrl

---
 rtl/display_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/display_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ==========================================================================
// display_pkg : shared FSM encodings and BCD constants for display_ctrl
// Rev 1.0
// ==========================================================================
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BCD_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;
  // One spare digit so 16-bit inputs convert exactly before truncation.
  localparam int ACC_DIGITS  = BCD_DIGITS + 1;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ==========================================================================
// bin2bcd_seq : sequential shift/add-3 binary-to-BCD engine, one bit/cycle
// Rev 1.0
// ==========================================================================
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BIN_WIDTH-1:0]      bin,
  output logic [ACC_DIGITS*4-1:0]   bcd,
  output logic                      done
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int ACC_W = ACC_DIGITS * 4;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]       bin_q, bin_d;
  logic [ACC_W-1:0]           bcd_q, bcd_d, bcd_adj;
  logic [ACC_W+BIN_WIDTH-1:0] shifted;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      bcd_adj[i*4 +: 4] = add3(bcd_q[i*4 +: 4]);
    end
    shifted = {bcd_adj, bin_q} << 1;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    if (start) begin
      cnt_d = CNT_W'(BIN_WIDTH);
      bin_d = bin;
      bcd_d = '0;
    end else if (cnt_q != '0) begin
      bcd_d = shifted[ACC_W+BIN_WIDTH-1 -: ACC_W];
      bin_d = shifted[BIN_WIDTH-1:0];
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  // done marks the final shift cycle; bcd holds the full result from the next edge.
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/display_ctrl.sv
`default_nettype none
// ==========================================================================
// display_ctrl : round-robin two-requester BCD display controller
// Rev 1.0 | optional saturation when DISPLAY_CTRL_SAT_EN is defined
// ==========================================================================
module display_ctrl
  import display_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [BIN_WIDTH-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [BIN_WIDTH-1:0] data1,
  output logic                 ack1,
  output logic [3:0]           segment0,
  output logic [3:0]           segment1,
  output logic [3:0]           segment2,
  output logic [3:0]           segment3,
  output logic                 busy,
  output logic                 overflow
);

  localparam int ACC_W = ACC_DIGITS * 4;
  localparam int SEG_W = BCD_DIGITS * 4;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic [BIN_WIDTH-1:0] data_q, data_d;
  logic [SEG_W-1:0]     seg_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 start;
  logic                 conv_done;
  logic [ACC_W-1:0]     bcd;

  bin2bcd_seq #(
    .BIN_WIDTH(BIN_WIDTH)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bin  (data_q),
    .bcd  (bcd),
    .done (conv_done)
  );

  // grant_q doubles as last_grant and as the owner of the running conversion.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? ~grant_q : req1;
          data_d  = grant_d ? data1 : data0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (conv_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DISPLAY_CTRL_SAT_EN
  always_comb begin
    ovf_d  = (bcd[ACC_W-1 -: 4] != 4'd0);
    disp_d = ovf_d ? {BCD_DIGITS{4'd9}} : bcd[SEG_W-1:0];
  end
`else
  logic unused_top_digit;
  assign unused_top_digit = ^bcd[ACC_W-1 -: 4];

  always_comb begin
    ovf_d  = 1'b0;
    disp_d = bcd[SEG_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      data_q  <= '0;
      seg_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      if (state_q == DONE) begin
        seg_q <= disp_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign ack0     = (state_q == DONE) && !grant_q;
  assign ack1     = (state_q == DONE) &&  grant_q;
  assign segment0 = seg_q[3:0];
  assign segment1 = seg_q[7:4];
  assign segment2 = seg_q[11:8];
  assign segment3 = seg_q[15:12];
  assign overflow = ovf_q;

endmodule
`default_nettype wire
